// File: rtl/id_ex_stage_if.sv
// rtl/id_ex_stage_if.sv - decode, forwarding and ALU-side signal bundle for the ID/EX register
interface id_ex_stage_if #(
  parameter int XLEN   = 32,
  parameter int FUNC_W = 5
);
  logic              flush;
  logic              dec_valid;
  logic              dec_ready;
  logic [FUNC_W-1:0] dec_alu_function;
  logic [4:0]        dec_rs1_addr;
  logic [4:0]        dec_rs2_addr;
  logic [XLEN-1:0]   dec_rs1_data;
  logic [XLEN-1:0]   dec_rs2_data;
  logic [XLEN-1:0]   dec_imm;
  logic              dec_use_imm;
  logic [XLEN-1:0]   dec_pc;
  logic              dec_use_pc;
  logic [4:0]        dec_rd_addr;
  logic              dec_rd_we;
  logic [4:0]        mem_rd_addr;
  logic              mem_rd_we;
  logic              mem_is_load;
  logic [XLEN-1:0]   mem_result;
  logic [4:0]        wb_rd_addr;
  logic              wb_rd_we;
  logic [XLEN-1:0]   wb_result;
  logic              ex_valid;
  logic              ex_ready;
  logic [FUNC_W-1:0] ex_alu_function;
  logic [XLEN-1:0]   ex_operand_a;
  logic [XLEN-1:0]   ex_operand_b;
  logic [4:0]        ex_rd_addr;
  logic              ex_rd_we;

  // Surrounding pipeline (decoder, MEM, WB, ALU) drives this side
  modport master (
    output flush, dec_valid, dec_alu_function, dec_rs1_addr, dec_rs2_addr,
           dec_rs1_data, dec_rs2_data, dec_imm, dec_use_imm, dec_pc, dec_use_pc,
           dec_rd_addr, dec_rd_we, mem_rd_addr, mem_rd_we, mem_is_load, mem_result,
           wb_rd_addr, wb_rd_we, wb_result, ex_ready,
    input  dec_ready, ex_valid, ex_alu_function, ex_operand_a, ex_operand_b,
           ex_rd_addr, ex_rd_we
  );

  // The ID/EX stage itself
  modport slave (
    input  flush, dec_valid, dec_alu_function, dec_rs1_addr, dec_rs2_addr,
           dec_rs1_data, dec_rs2_data, dec_imm, dec_use_imm, dec_pc, dec_use_pc,
           dec_rd_addr, dec_rd_we, mem_rd_addr, mem_rd_we, mem_is_load, mem_result,
           wb_rd_addr, wb_rd_we, wb_result, ex_ready,
    output dec_ready, ex_valid, ex_alu_function, ex_operand_a, ex_operand_b,
           ex_rd_addr, ex_rd_we
  );
endinterface

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - single-entry ID/EX register with forwarding and hazard stall (option: ID_EX_FORWARD_EN)
module id_ex_stage #(
  parameter int XLEN   = 32,
  parameter int FUNC_W = 5
) (
  input logic          clk,
  input logic          rst_n,
  id_ex_stage_if.slave bus
);

  logic              w_rs1_used;
  logic              w_rs2_used;
  logic              w_mem_rs1;
  logic              w_mem_rs2;
  logic              w_wb_rs1;
  logic              w_wb_rs2;
  logic              w_hz;
  logic              w_ready;
  logic              w_capture;
  logic [XLEN-1:0]   w_fwd_rs1;
  logic [XLEN-1:0]   w_fwd_rs2;
  logic [XLEN-1:0]   w_op_a;
  logic [XLEN-1:0]   w_op_b;

  logic              r_valid;
  logic [FUNC_W-1:0] r_func;
  logic [XLEN-1:0]   r_op_a;
  logic [XLEN-1:0]   r_op_b;
  logic [4:0]        r_rd_addr;
  logic              r_rd_we;

  // A source only matters when it is a real register and not replaced by PC/immediate
  assign w_rs1_used = !bus.dec_use_pc  && (bus.dec_rs1_addr != 5'd0);
  assign w_rs2_used = !bus.dec_use_imm && (bus.dec_rs2_addr != 5'd0);

  assign w_mem_rs1 = bus.mem_rd_we && (bus.mem_rd_addr == bus.dec_rs1_addr);
  assign w_mem_rs2 = bus.mem_rd_we && (bus.mem_rd_addr == bus.dec_rs2_addr);
  assign w_wb_rs1  = bus.wb_rd_we  && (bus.wb_rd_addr  == bus.dec_rs1_addr);
  assign w_wb_rs2  = bus.wb_rd_we  && (bus.wb_rd_addr  == bus.dec_rs2_addr);

`ifdef ID_EX_FORWARD_EN
  // Only a load in MEM has no value yet; everything else can be forwarded
  assign w_hz = bus.dec_valid && bus.mem_is_load &&
                ((w_rs1_used && w_mem_rs1) || (w_rs2_used && w_mem_rs2));

  // rs1 value: x0 is zero, then MEM (non-load) over WB over register file
  always_comb begin
    w_fwd_rs1 = bus.dec_rs1_data;
    if (bus.dec_rs1_addr == 5'd0) begin
      w_fwd_rs1 = '0;
    end else if (w_mem_rs1 && !bus.mem_is_load) begin
      w_fwd_rs1 = bus.mem_result;
    end else if (w_wb_rs1) begin
      w_fwd_rs1 = bus.wb_result;
    end
  end

  // rs2 value: same priority as rs1
  always_comb begin
    w_fwd_rs2 = bus.dec_rs2_data;
    if (bus.dec_rs2_addr == 5'd0) begin
      w_fwd_rs2 = '0;
    end else if (w_mem_rs2 && !bus.mem_is_load) begin
      w_fwd_rs2 = bus.mem_result;
    end else if (w_wb_rs2) begin
      w_fwd_rs2 = bus.wb_result;
    end
  end
`else
  // Without bypass paths any in-flight writer of a used source must drain first
  assign w_hz = bus.dec_valid &&
                ((w_rs1_used && (w_mem_rs1 || w_wb_rs1)) ||
                 (w_rs2_used && (w_mem_rs2 || w_wb_rs2)));

  assign w_fwd_rs1 = (bus.dec_rs1_addr == 5'd0) ? '0 : bus.dec_rs1_data;
  assign w_fwd_rs2 = (bus.dec_rs2_addr == 5'd0) ? '0 : bus.dec_rs2_data;

  logic w_unused_fwd;
  assign w_unused_fwd = ^{bus.mem_is_load, bus.mem_result, bus.wb_result};
`endif

  assign w_op_a = bus.dec_use_pc  ? bus.dec_pc  : w_fwd_rs1;
  assign w_op_b = bus.dec_use_imm ? bus.dec_imm : w_fwd_rs2;

  // Accept when the slot is free or being consumed, no stall, no redirect, not in reset
  assign w_ready   = rst_n && (!r_valid || bus.ex_ready) && !w_hz && !bus.flush;
  assign w_capture = bus.dec_valid && w_ready;

  // Entry occupancy: flush kills, capture fills, consumption without capture empties
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
    end else if (bus.flush) begin
      r_valid <= 1'b0;
    end else if (w_capture) begin
      r_valid <= 1'b1;
    end else if (bus.ex_ready) begin
      r_valid <= 1'b0;
    end
  end

  // Payload loads only on capture; left untouched on drain/flush since r_valid qualifies it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_func    <= '0;
      r_op_a    <= '0;
      r_op_b    <= '0;
      r_rd_addr <= '0;
      r_rd_we   <= 1'b0;
    end else if (w_capture) begin
      r_func    <= bus.dec_alu_function;
      r_op_a    <= w_op_a;
      r_op_b    <= w_op_b;
      r_rd_addr <= bus.dec_rd_addr;
      r_rd_we   <= bus.dec_rd_we;
    end
  end

  assign bus.dec_ready       = w_ready;
  assign bus.ex_valid        = r_valid;
  assign bus.ex_alu_function = r_func;
  assign bus.ex_operand_a    = r_op_a;
  assign bus.ex_operand_b    = r_op_b;
  assign bus.ex_rd_addr      = r_rd_addr;
  assign bus.ex_rd_we        = r_rd_we;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - randomized and directed bench for id_ex_stage against a behavioural model
module tb_id_ex_stage;
  localparam int XLEN   = 32;
  localparam int FUNC_W = 5;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  id_ex_stage_if #(.XLEN(XLEN), .FUNC_W(FUNC_W)) bus ();

  id_ex_stage #(.XLEN(XLEN), .FUNC_W(FUNC_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_vec  = 0;
  int n_miss = 0;

  logic              m_valid;
  logic [FUNC_W-1:0] m_func;
  logic [XLEN-1:0]   m_a;
  logic [XLEN-1:0]   m_b;
  logic [4:0]        m_rd;
  logic              m_we;
  logic              s_ready;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0; m_func = '0; m_a = '0; m_b = '0; m_rd = '0; m_we = 1'b0;
  endtask

  // Is a value for register idx still unavailable to this stage?
  function automatic logic pending(input logic [4:0] idx);
    if (idx == 5'd0) return 1'b0;
`ifdef ID_EX_FORWARD_EN
    return bus.mem_rd_we && bus.mem_is_load && (bus.mem_rd_addr == idx);
`else
    return (bus.mem_rd_we && (bus.mem_rd_addr == idx)) ||
           (bus.wb_rd_we && (bus.wb_rd_addr == idx));
`endif
  endfunction

  // Architectural value of register idx as seen at decode
  function automatic logic [XLEN-1:0] src_val(input logic [4:0] idx, input logic [XLEN-1:0] rf);
    if (idx == 5'd0) return '0;
`ifdef ID_EX_FORWARD_EN
    if (bus.mem_rd_we && !bus.mem_is_load && bus.mem_rd_addr == idx) return bus.mem_result;
    if (bus.wb_rd_we && bus.wb_rd_addr == idx) return bus.wb_result;
`endif
    return rf;
  endfunction

  function automatic logic exp_ready();
    logic stall;
    stall = bus.dec_valid && ((!bus.dec_use_pc  && pending(bus.dec_rs1_addr)) ||
                              (!bus.dec_use_imm && pending(bus.dec_rs2_addr)));
    return rst_n && (!m_valid || bus.ex_ready) && !stall && !bus.flush;
  endfunction

  // One cycle: check ready mid-cycle, predict the edge, compare all outputs after it
  task automatic step();
    logic              cap;
    logic              nv;
    logic [FUNC_W-1:0] nf;
    logic [XLEN-1:0]   na, nb;
    logic [4:0]        nrd;
    logic              nwe;
    #4;
    s_ready = bus.dec_ready;
    chk("dec_ready", bus.dec_ready, exp_ready());
    cap = bus.dec_valid && exp_ready();
    nv = m_valid; nf = m_func; na = m_a; nb = m_b; nrd = m_rd; nwe = m_we;
    if (bus.flush) begin
      nv = 1'b0;
    end else if (cap) begin
      nv  = 1'b1;
      nf  = bus.dec_alu_function;
      na  = bus.dec_use_pc  ? bus.dec_pc  : src_val(bus.dec_rs1_addr, bus.dec_rs1_data);
      nb  = bus.dec_use_imm ? bus.dec_imm : src_val(bus.dec_rs2_addr, bus.dec_rs2_data);
      nrd = bus.dec_rd_addr;
      nwe = bus.dec_rd_we;
    end else if (m_valid && bus.ex_ready) begin
      nv = 1'b0;
    end
    @(posedge clk);
    #1;
    m_valid = nv; m_func = nf; m_a = na; m_b = nb; m_rd = nrd; m_we = nwe;
    chk("ex_valid", bus.ex_valid, m_valid);
    chk("ex_alu_function", bus.ex_alu_function, m_func);
    chk("ex_operand_a", bus.ex_operand_a, m_a);
    chk("ex_operand_b", bus.ex_operand_b, m_b);
    chk("ex_rd_addr", bus.ex_rd_addr, m_rd);
    chk("ex_rd_we", bus.ex_rd_we, m_we);
  endtask

  task automatic idle();
    bus.flush = 0; bus.dec_valid = 0; bus.dec_alu_function = '0;
    bus.dec_rs1_addr = '0; bus.dec_rs2_addr = '0; bus.dec_rs1_data = '0; bus.dec_rs2_data = '0;
    bus.dec_imm = '0; bus.dec_use_imm = 0; bus.dec_pc = '0; bus.dec_use_pc = 0;
    bus.dec_rd_addr = '0; bus.dec_rd_we = 0;
    bus.mem_rd_addr = '0; bus.mem_rd_we = 0; bus.mem_is_load = 0; bus.mem_result = '0;
    bus.wb_rd_addr = '0; bus.wb_rd_we = 0; bus.wb_result = '0; bus.ex_ready = 1;
  endtask

  task automatic set_dec(input logic [4:0] f, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                         input logic use_imm, input logic [4:0] rd);
    bus.dec_valid = 1; bus.dec_alu_function = f;
    bus.dec_rs1_addr = rs1; bus.dec_rs2_addr = rs2; bus.dec_rs1_data = d1; bus.dec_rs2_data = d2;
    bus.dec_imm = imm; bus.dec_use_imm = use_imm; bus.dec_pc = 32'h1000; bus.dec_use_pc = 0;
    bus.dec_rd_addr = rd; bus.dec_rd_we = 1;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    model_reset();
    s_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ex_valid", bus.ex_valid, 0);
    chk("reset_operand_a", bus.ex_operand_a, 0);
    chk("reset_dec_ready", bus.dec_ready, 0);
    rst_n = 1'b1;

    // ADD x3,x1,x2 then a second instruction back to back
    set_dec(5'b00001, 5'd1, 5'd2, 32'd5, 32'd7, 32'd0, 0, 5'd3);
    step();
    chk("add_func", bus.ex_alu_function, 5'b00001);
    chk("add_opa", bus.ex_operand_a, 32'd5);
    chk("add_opb", bus.ex_operand_b, 32'd7);
    chk("add_valid", bus.ex_valid, 1);
    set_dec(5'b00010, 5'd5, 5'd6, 32'd10, 32'd4, 32'd0, 0, 5'd7);
    step();
    chk("b2b_ready", s_ready, 1);
    chk("b2b_opa", bus.ex_operand_a, 32'd10);

`ifdef ID_EX_FORWARD_EN
    // Forward priority MEM > WB > RF, x0 never forwarded
    set_dec(5'b00001, 5'd4, 5'd0, 32'h33, 32'h0, 32'h0, 1, 5'd8);
    bus.mem_rd_addr = 5'd4; bus.mem_rd_we = 1; bus.mem_result = 32'h11;
    bus.wb_rd_addr = 5'd4; bus.wb_rd_we = 1; bus.wb_result = 32'h22;
    step();
    chk("fwd_mem", bus.ex_operand_a, 32'h11);
    bus.mem_rd_we = 0;
    step();
    chk("fwd_wb", bus.ex_operand_a, 32'h22);
    bus.dec_rs1_addr = 5'd0; bus.dec_rs1_data = 32'h0;
    step();
    chk("fwd_x0", bus.ex_operand_a, 32'h0);

    // Load-use on rs2: one bubble, then forwarded capture
    idle();
    set_dec(5'b00001, 5'd1, 5'd6, 32'h1, 32'h44, 32'h0, 0, 5'd9);
    bus.mem_rd_addr = 5'd6; bus.mem_rd_we = 1; bus.mem_is_load = 1; bus.mem_result = 32'h66;
    step();
    chk("lu_ready", s_ready, 0);
    chk("lu_bubble", bus.ex_valid, 0);
    bus.mem_is_load = 0;
    step();
    chk("lu_ready2", s_ready, 1);
    chk("lu_opb", bus.ex_operand_b, 32'h66);
    bus.mem_is_load = 1; bus.dec_use_imm = 1; bus.dec_imm = 32'hFFFF_FFF0;
    step();
    chk("lu_imm_ready", s_ready, 1);
    chk("lu_imm_opb", bus.ex_operand_b, 32'hFFFF_FFF0);
`else
    // No bypass: WB writer of rs1 stalls until it retires
    idle();
    set_dec(5'b00001, 5'd9, 5'd0, 32'h99, 32'h0, 32'h5, 1, 5'd10);
    bus.wb_rd_addr = 5'd9; bus.wb_rd_we = 1; bus.wb_result = 32'h77;
    step();
    chk("nofwd_ready", s_ready, 0);
    step();
    chk("nofwd_bubble", bus.ex_valid, 0);
    bus.wb_rd_we = 0;
    step();
    chk("nofwd_ready2", s_ready, 1);
    chk("nofwd_opa", bus.ex_operand_a, 32'h99);
`endif

    // Backpressure for three cycles, then flush with an instruction on offer
    idle();
    set_dec(5'b00011, 5'd1, 5'd2, 32'hA5, 32'h3, 32'h0, 0, 5'd11);
    step();
    bus.ex_ready = 0;
    set_dec(5'b00100, 5'd1, 5'd2, 32'h5A, 32'h4, 32'h0, 0, 5'd12);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_ready", s_ready, 0);
      chk("bp_opa", bus.ex_operand_a, 32'hA5);
      chk("bp_valid", bus.ex_valid, 1);
    end
    bus.flush = 1;
    step();
    chk("flush_valid", bus.ex_valid, 0);
    chk("flush_ready", s_ready, 0);
    bus.flush = 0;

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      bus.dec_valid = ($urandom % 4) != 0;
      bus.ex_ready = ($urandom % 4) != 0;
      bus.flush = ($urandom % 16) == 0;
      bus.dec_alu_function = FUNC_W'($urandom_range(1, 11));
      bus.dec_rs1_addr = 5'($urandom % 8);
      bus.dec_rs2_addr = 5'($urandom % 8);
      bus.dec_rs1_data = (bus.dec_rs1_addr == 0) ? 32'h0 : $urandom;
      bus.dec_rs2_data = (bus.dec_rs2_addr == 0) ? 32'h0 : $urandom;
      bus.dec_imm = $urandom;
      bus.dec_use_imm = ($urandom % 4) == 0;
      bus.dec_pc = $urandom;
      bus.dec_use_pc = ($urandom % 4) == 0;
      bus.dec_rd_addr = 5'($urandom);
      bus.dec_rd_we = 1'($urandom);
      bus.mem_rd_addr = 5'($urandom % 8);
      bus.mem_rd_we = ($urandom % 2) == 0;
      bus.mem_is_load = ($urandom % 3) == 0;
      bus.mem_result = $urandom;
      bus.wb_rd_addr = 5'($urandom % 8);
      bus.wb_rd_we = ($urandom % 2) == 0;
      bus.wb_result = $urandom;
      step();
    end

    // Reset asserted mid-cycle with a valid entry held
    idle();
    set_dec(5'b00101, 5'd1, 5'd2, 32'hBEEF, 32'hCAFE, 32'h0, 0, 5'd13);
    step();
    chk("prereset_valid", bus.ex_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset_valid", bus.ex_valid, 0);
    chk("midreset_func", bus.ex_alu_function, 0);
    chk("midreset_opa", bus.ex_operand_a, 0);
    chk("midreset_opb", bus.ex_operand_b, 0);
    chk("midreset_rd", bus.ex_rd_addr, 0);
    chk("midreset_we", bus.ex_rd_we, 0);
    chk("midreset_ready", bus.dec_ready, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
